query_patch_pingpong_mem: RTL and testbench

Double-buffered query-patch store for the ANN query path. Query patches arrive from the I/O aggregator and are written into one of two banks, while the compute side reads the other bank. The banks swap ownership when the writer completes a bank (full or frame-terminated) and the reader releases its bank. This lets query I/O for batch N+1 overlap search computation on batch N.

---
 rtl/query_patch_pingpong_mem_pkg.sv | 17 +
 rtl/query_patch_pingpong_mem_if.sv | 29 ++
 rtl/pingpong_ctrl.sv | 82 ++++++++
 rtl/ram_sync_1r1w.sv | 26 ++
 rtl/query_patch_pingpong_mem.sv | 91 +++++++++
 tb/tb_query_patch_pingpong_mem.sv | 343 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/query_patch_pingpong_mem_pkg.sv
// Shared types and constants for the double-buffered query-patch store.
// Drop counting is built only when QUERY_PATCH_MEM_DROP_CNT_EN is defined (see top level).
package query_patch_pingpong_mem_pkg;

  typedef logic bank_idx_t;

  localparam int unsigned DefDataWidth = 55;
  localparam int unsigned DefAddrWidth = 7;
  localparam int unsigned DefDepth     = 128;
  localparam int unsigned LastAddr     = DefDepth - 1;
  localparam int unsigned DropCntWidth = 16;

  function automatic int unsigned last_addr(input int unsigned depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/query_patch_pingpong_mem_if.sv
// Write handshake and reader-side bus of the query-patch ping-pong store.
interface query_patch_pingpong_mem_if #(
  parameter int unsigned DATA_WIDTH = 55,
  parameter int unsigned ADDR_WIDTH = 7
) ();

  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_last;
  logic                  wr_ready;
  logic                  rd_bank_valid;
  logic [ADDR_WIDTH:0]   rd_count;
  logic                  ren;
  logic [ADDR_WIDTH-1:0] radr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_valid;
  logic                  rd_done;

  modport master (
    output wr_valid, wr_data, wr_last, ren, radr, rd_done,
    input  wr_ready, rd_bank_valid, rd_count, rdata, rdata_valid
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, ren, radr, rd_done,
    output wr_ready, rd_bank_valid, rd_count, rdata, rdata_valid
  );

endinterface

// File: rtl/pingpong_ctrl.sv
// Bank ownership for the ping-pong store: write/read bank pointers, fill address,
// per-bank full flags and lengths, and the write handshake.
module pingpong_ctrl
  import query_patch_pingpong_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DEPTH      = DefDepth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fsm_enable,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  input  logic                  rd_done,
  output logic                  wr_ready,
  output logic                  wr_en,
  output bank_idx_t             wr_bank,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  rd_bank_valid,
  output bank_idx_t             rd_bank,
  output logic [ADDR_WIDTH:0]   rd_count
);

  localparam logic [ADDR_WIDTH-1:0] LastA = ADDR_WIDTH'(last_addr(DEPTH));

  bank_idx_t             wb_q, wb_d, rb_q, rb_d;
  logic [ADDR_WIDTH-1:0] wadr_q, wadr_d;
  logic [1:0]            full_q, full_d;
  logic [ADDR_WIDTH:0]   len_q [2];
  logic [ADDR_WIDTH:0]   len_d [2];
  logic                  close, rd_rel;

  // A close needs the write bank empty and a release needs the read bank full,
  // so when both fire in one cycle they always touch different banks.
  always_comb begin
    wb_d   = wb_q;
    rb_d   = rb_q;
    wadr_d = wadr_q;
    full_d = full_q;
    len_d  = len_q;

    wr_ready = rst_n && fsm_enable && !full_q[wb_q];
    wr_en    = wr_valid && wr_ready;
    close    = wr_en && ((wadr_q == LastA) || wr_last);
    rd_rel   = rd_done && full_q[rb_q];

    if (wr_en) wadr_d = wadr_q + ADDR_WIDTH'(1);
    if (close) begin
      full_d[wb_q] = 1'b1;
      len_d[wb_q]  = {1'b0, wadr_q} + (ADDR_WIDTH + 1)'(1);
      wb_d         = ~wb_q;
      wadr_d       = '0;
    end
    if (rd_rel) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      wadr_q <= '0;
      full_q <= '0;
      len_q  <= '{default: '0};
    end else begin
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      wadr_q <= wadr_d;
      full_q <= full_d;
      len_q  <= len_d;
    end
  end

  assign wr_bank       = wb_q;
  assign wr_addr       = wadr_q;
  assign rd_bank       = rb_q;
  assign rd_bank_valid = full_q[rb_q];
  assign rd_count      = full_q[rb_q] ? len_q[rb_q] : '0;

endmodule

// File: rtl/ram_sync_1r1w.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module ram_sync_1r1w #(
  parameter int unsigned WIDTH      = 55,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/query_patch_pingpong_mem.sv
// Double-buffered query-patch store: two bank RAMs, registered read mux, optional
// drop counter enabled by QUERY_PATCH_MEM_DROP_CNT_EN.
module query_patch_pingpong_mem
  import query_patch_pingpong_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DEPTH      = DefDepth
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fsm_enable,
  query_patch_pingpong_mem_if.slave bus,
  output logic [DropCntWidth-1:0] drop_count
);

  logic                  wr_en, rd_acc;
  bank_idx_t             wr_bank, rd_bank, rsel_q;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_bank_valid, rvalid_q;
  logic [DATA_WIDTH-1:0] bank_rdata [2];

  pingpong_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .fsm_enable   (fsm_enable),
    .wr_valid     (bus.wr_valid),
    .wr_last      (bus.wr_last),
    .rd_done      (bus.rd_done),
    .wr_ready     (bus.wr_ready),
    .wr_en        (wr_en),
    .wr_bank      (wr_bank),
    .wr_addr      (wr_addr),
    .rd_bank_valid(rd_bank_valid),
    .rd_bank      (rd_bank),
    .rd_count     (bus.rd_count)
  );

  assign rd_acc = bus.ren && rd_bank_valid;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ram_sync_1r1w #(
      .WIDTH     (DATA_WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
      .clk  (clk),
      .we   (wr_en && (wr_bank == bank_idx_t'(b))),
      .waddr(wr_addr),
      .wdata(bus.wr_data),
      .re   (rd_acc && (rd_bank == bank_idx_t'(b))),
      .raddr(bus.radr),
      .rdata(bank_rdata[b])
    );
  end

  // Bank select is captured at accept time so a same-cycle rd_done still reads the old bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rsel_q   <= 1'b0;
    end else begin
      rvalid_q <= rd_acc;
      if (rd_acc) rsel_q <= rd_bank;
    end
  end

  assign bus.rd_bank_valid = rd_bank_valid;
  assign bus.rdata_valid   = rvalid_q;
  assign bus.rdata         = rvalid_q ? bank_rdata[rsel_q] : '0;

`ifdef QUERY_PATCH_MEM_DROP_CNT_EN
  logic [DropCntWidth-1:0] drop_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (fsm_enable && bus.wr_valid && !bus.wr_ready && (drop_q != '1)) begin
      drop_q <= drop_q + DropCntWidth'(1);
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_query_patch_pingpong_mem.sv
// Self-checking bench for query_patch_pingpong_mem against a queue-based batch model.
module tb_query_patch_pingpong_mem;

  localparam int DW  = 55;
  localparam int AW  = 7;
  localparam int DEP = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fsm_enable;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  query_patch_pingpong_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  query_patch_pingpong_mem #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fsm_enable(fsm_enable),
    .bus       (bus),
    .drop_count(drop_count)
  );

  // Model: completed batches in order (oldest owned by reader), plus the batch being filled.
  logic [DW-1:0] cur_q[$];
  logic [DW-1:0] done_data[$];
  int            done_len[$];
  logic          exp_rv;
  logic [DW-1:0] exp_rd;
  int            exp_drop;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  function automatic logic exp_ready();
    return rst_n && fsm_enable && (done_len.size() < 2);
  endfunction

  function automatic logic exp_rbv();
    return done_len.size() > 0;
  endfunction

  function automatic logic [AW:0] exp_cnt();
    if (done_len.size() == 0) return '0;
    return (AW + 1)'(done_len[0]);
  endfunction

  function automatic logic [15:0] exp_dc();
`ifdef QUERY_PATCH_MEM_DROP_CNT_EN
    return 16'(exp_drop);
`else
    return 16'd0;
`endif
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, land on the next negedge.
  task automatic step(input bit rst, input bit en, input bit wv, input logic [DW-1:0] wd,
                      input bit wl, input bit ren, input int radr, input bit rdone);
    rst_n        = rst;
    fsm_enable   = en;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.wr_last  = wl;
    bus.ren      = ren;
    bus.radr     = AW'(radr);
    bus.rd_done  = rdone;
    if (!rst) begin
      cur_q.delete();
      done_data.delete();
      done_len.delete();
      exp_rv   = 1'b0;
      exp_rd   = '0;
      exp_drop = 0;
    end else begin
      bit ready;
      bit rbv;
      ready = en && (done_len.size() < 2);
      rbv   = done_len.size() > 0;
      if (ren && rbv) begin
        exp_rv = 1'b1;
        exp_rd = done_data[radr];
      end else begin
        exp_rv = 1'b0;
        exp_rd = '0;
      end
      if (en && wv && !ready && exp_drop < 65535) exp_drop++;
      if (rdone && rbv) begin
        repeat (done_len[0]) void'(done_data.pop_front());
        void'(done_len.pop_front());
      end
      if (wv && ready) begin
        cur_q.push_back(wd);
        if (cur_q.size() == DEP || wl) begin
          foreach (cur_q[i]) done_data.push_back(cur_q[i]);
          done_len.push_back(cur_q.size());
          cur_q.delete();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1, 1, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 1, 0, '0, 0, 0, 0, 0);
    step(0, 1, 1, '0, 0, 1, 0, 1);
    checks++;
    if (bus.wr_ready !== 1'b0) begin
      errors++; $display("FAIL reset_wr_ready got %0b want 0", bus.wr_ready);
    end
    checks++;
    if (bus.rd_bank_valid !== 1'b0 || bus.rd_count !== '0) begin
      errors++;
      $display("FAIL reset_rd got rbv=%0b cnt=%0d want 0/0", bus.rd_bank_valid, bus.rd_count);
    end
    checks++;
    if (bus.rdata_valid !== 1'b0 || bus.rdata !== '0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_out got rv=%0b rd=%0h dc=%0d want 0", bus.rdata_valid, bus.rdata,
               drop_count);
    end
    idle();
    checks++;
    if (bus.wr_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready got %0b want 1", bus.wr_ready);
    end
  endtask

  task automatic test_full_bank();
    for (int i = 0; i < DEP; i++) begin
      step(1, 1, 1, DW'(i), 0, 0, 0, 0);
      checks++;
      if (bus.wr_ready !== 1'b1) begin
        errors++; $display("FAIL fill_ready i=%0d got %0b want 1", i, bus.wr_ready);
      end
    end
    checks++;
    if (bus.rd_bank_valid !== 1'b1 || bus.rd_count !== 8'd128) begin
      errors++;
      $display("FAIL fill_count got rbv=%0b cnt=%0d want 1/128", bus.rd_bank_valid,
               bus.rd_count);
    end
    for (int i = 0; i < DEP; i++) begin
      step(1, 1, 0, '0, 0, 1, i, 0);
      checks++;
      if (bus.rdata_valid !== 1'b1 || bus.rdata !== DW'(i) || bus.rdata !== exp_rd) begin
        errors++;
        $display("FAIL fill_read a=%0d got %0b/%0h want 1/%0h", i, bus.rdata_valid,
                 bus.rdata, i);
      end
    end
    step(1, 1, 0, '0, 0, 0, 0, 1);
    checks++;
    if (bus.rd_bank_valid !== 1'b0 || bus.rdata_valid !== 1'b0 || bus.rdata !== '0) begin
      errors++;
      $display("FAIL fill_release got rbv=%0b rv=%0b rd=%0h want 0/0/0", bus.rd_bank_valid,
               bus.rdata_valid, bus.rdata);
    end
  endtask

  task automatic test_wr_last();
    logic [DW-1:0] x;
    for (int i = 0; i < 5; i++) step(1, 1, 1, DW'(100 + i), i == 4, 0, 0, 0);
    checks++;
    if (bus.rd_bank_valid !== 1'b1 || bus.rd_count !== 8'd5) begin
      errors++;
      $display("FAIL last_count got rbv=%0b cnt=%0d want 1/5", bus.rd_bank_valid, bus.rd_count);
    end
    x = rnd_data();
    step(1, 1, 1, x, 1, 0, 0, 0);
    checks++;
    if (bus.wr_ready !== 1'b0) begin
      errors++; $display("FAIL last_both_full got %0b want 0", bus.wr_ready);
    end
    step(1, 1, 0, '0, 0, 0, 0, 1);
    checks++;
    if (bus.rd_count !== 8'd1 || bus.rd_count !== exp_cnt()) begin
      errors++; $display("FAIL last_next_count got %0d want 1", bus.rd_count);
    end
    step(1, 1, 0, '0, 0, 1, 0, 0);
    checks++;
    if (bus.rdata !== x || bus.rdata_valid !== 1'b1) begin
      errors++; $display("FAIL last_next_data got %0h want %0h", bus.rdata, x);
    end
    step(1, 1, 0, '0, 0, 0, 0, 1);
  endtask

  task automatic test_both_full();
    for (int i = 0; i < 3; i++) step(1, 1, 1, rnd_data(), i == 2, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, rnd_data(), i == 3, 0, 0, 0);
    checks++;
    if (bus.wr_ready !== 1'b0) begin
      errors++; $display("FAIL full_ready got %0b want 0", bus.wr_ready);
    end
    for (int i = 0; i < 10; i++) step(1, 1, 1, rnd_data(), 0, 0, 0, 0);
    checks++;
    if (drop_count !== exp_dc()) begin
      errors++; $display("FAIL full_drops got %0d want %0d", drop_count, exp_dc());
    end
`ifdef QUERY_PATCH_MEM_DROP_CNT_EN
    checks++;
    if (drop_count !== 16'd10) begin
      errors++; $display("FAIL full_drops_ten got %0d want 10", drop_count);
    end
`endif
    step(1, 1, 0, '0, 0, 0, 0, 1);
    checks++;
    if (bus.wr_ready !== 1'b1 || bus.rd_count !== 8'd4) begin
      errors++;
      $display("FAIL full_release got rdy=%0b cnt=%0d want 1/4", bus.wr_ready, bus.rd_count);
    end
  endtask

  task automatic test_ren_with_done();
    for (int i = 0; i < 2; i++) step(1, 1, 1, rnd_data(), i == 1, 0, 0, 0);
    step(1, 1, 0, '0, 0, 1, 1, 1);
    checks++;
    if (bus.rdata_valid !== 1'b1 || bus.rdata !== exp_rd) begin
      errors++;
      $display("FAIL rd_done_data got %0b/%0h want 1/%0h", bus.rdata_valid, bus.rdata, exp_rd);
    end
    checks++;
    if (bus.rd_bank_valid !== 1'b1 || bus.rd_count !== 8'd2) begin
      errors++;
      $display("FAIL rd_done_next got rbv=%0b cnt=%0d want 1/2", bus.rd_bank_valid,
               bus.rd_count);
    end
    step(1, 1, 0, '0, 0, 0, 0, 1);
  endtask

  task automatic test_enable_gap();
    logic [DW-1:0] v[5];
    foreach (v[i]) v[i] = rnd_data();
    for (int i = 0; i < 3; i++) step(1, 1, 1, v[i], 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, rnd_data(), 1, 0, 0, 0);
      checks++;
      if (bus.wr_ready !== 1'b0 || bus.rd_bank_valid !== 1'b0) begin
        errors++;
        $display("FAIL gap_hold got rdy=%0b rbv=%0b want 0/0", bus.wr_ready,
                 bus.rd_bank_valid);
      end
    end
    for (int i = 3; i < 5; i++) step(1, 1, 1, v[i], i == 4, 0, 0, 0);
    checks++;
    if (bus.rd_count !== 8'd5) begin
      errors++; $display("FAIL gap_count got %0d want 5", bus.rd_count);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, '0, 0, 1, i, 0);
      checks++;
      if (bus.rdata !== v[i]) begin
        errors++; $display("FAIL gap_data a=%0d got %0h want %0h", i, bus.rdata, v[i]);
      end
    end
    step(1, 1, 0, '0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w;
    for (int i = 0; i < 3; i++) step(1, 1, 1, rnd_data(), 0, 0, 0, 0);
    step(0, 1, 0, '0, 0, 0, 0, 0);
    checks++;
    if (bus.wr_ready !== 1'b0 || bus.rd_bank_valid !== 1'b0 || bus.rd_count !== '0) begin
      errors++;
      $display("FAIL midfill_reset got rdy=%0b rbv=%0b cnt=%0d want 0", bus.wr_ready,
               bus.rd_bank_valid, bus.rd_count);
    end
    idle();
    for (int i = 0; i < 2; i++) step(1, 1, 1, rnd_data(), i == 1, 0, 0, 0);
    step(1, 1, 0, '0, 0, 1, 0, 0);
    step(0, 1, 0, '0, 0, 0, 0, 0);
    checks++;
    if (bus.rdata_valid !== 1'b0 || bus.rdata !== '0 || bus.rd_bank_valid !== 1'b0 ||
        drop_count !== 16'd0) begin
      errors++;
      $display("FAIL midread_reset got rv=%0b rd=%0h rbv=%0b dc=%0d want 0", bus.rdata_valid,
               bus.rdata, bus.rd_bank_valid, drop_count);
    end
    idle();
    w = rnd_data();
    step(1, 1, 1, w, 1, 0, 0, 0);
    step(1, 1, 0, '0, 0, 1, 0, 0);
    checks++;
    if (bus.rd_count !== 8'd1 || bus.rdata !== w) begin
      errors++;
      $display("FAIL post_reset_write got cnt=%0d rd=%0h want 1/%0h", bus.rd_count, bus.rdata,
               w);
    end
    step(1, 1, 0, '0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      bit en, wv, wl, ren, rdone;
      int radr;
      en    = ($urandom % 8) != 0;
      wv    = ($urandom % 4) != 0;
      wl    = ($urandom % 16) == 0;
      ren   = ($urandom % 2) == 0;
      rdone = ($urandom % 12) == 0;
      radr  = (done_len.size() > 0) ? int'($urandom % done_len[0]) : int'($urandom % DEP);
      step(1, en, wv, rnd_data(), wl, ren, radr, rdone);
      checks++;
      if (bus.wr_ready !== exp_ready() || bus.rd_bank_valid !== exp_rbv() ||
          bus.rd_count !== exp_cnt() || bus.rdata_valid !== exp_rv ||
          bus.rdata !== exp_rd || drop_count !== exp_dc()) begin
        errors++;
        $display("FAIL rand n=%0d got rdy=%0b rbv=%0b cnt=%0d rv=%0b rd=%0h dc=%0d want %0b %0b %0d %0b %0h %0d",
                 n, bus.wr_ready, bus.rd_bank_valid, bus.rd_count, bus.rdata_valid,
                 bus.rdata, drop_count, exp_ready(), exp_rbv(), exp_cnt(), exp_rv, exp_rd,
                 exp_dc());
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_bank();
    test_wr_last();
    test_both_full();
    test_ren_with_done();
    test_enable_gap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
